// File: rtl/rv_pkg.sv
// Shared RV32 decode constants.
// NOP_INSTR is the bubble word (addi x0,x0,0). The field widths are shared by
// the IF/ID queue and by any later decode-side stage.
package rv_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam int OPCODE_W = 7;
   localparam int REG_W    = 5;
   localparam int FUNCT3_W = 3;
   localparam int FUNCT7_W = 7;
   localparam int IMM12_W  = 12;
   localparam int IMM20_W  = 20;

endpackage

// File: rtl/if_id_fields.sv
// Purely combinational RV32 field extraction.
// Ports:
//   instr              : 32-bit instruction word
//   opcode, rd, rs1, rs2, funct3, funct7 : register and function fields
//   imm_I, imm_S, imm_B, imm_U, imm_J    : raw immediates. They are not
//                                          sign-extended, and the implied low
//                                          zero bits of B/J/U are dropped.
module if_id_fields
   import rv_pkg::*;
(
   input  logic [31:0]          instr,
   output logic [OPCODE_W-1:0]  opcode,
   output logic [REG_W-1:0]     rd,
   output logic [REG_W-1:0]     rs1,
   output logic [REG_W-1:0]     rs2,
   output logic [FUNCT3_W-1:0]  funct3,
   output logic [FUNCT7_W-1:0]  funct7,
   output logic [IMM12_W-1:0]   imm_I,
   output logic [IMM12_W-1:0]   imm_S,
   output logic [IMM12_W-1:0]   imm_B,
   output logic [IMM20_W-1:0]   imm_U,
   output logic [IMM20_W-1:0]   imm_J
);

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign funct7 = instr[31:25];

   assign imm_I  = instr[31:20];
   assign imm_S  = {instr[31:25], instr[11:7]};
   assign imm_B  = {instr[31], instr[7], instr[30:25], instr[11:8]};
   assign imm_U  = instr[31:12];
   assign imm_J  = {instr[31], instr[19:12], instr[20], instr[30:21]};

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue. This is a DEPTH-entry FIFO of {instr, pc, pred}
// between fetch and decode. It presents a NOP bubble when empty, and decode
// fields are extracted from the head entry.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   flush                   : empty the queue at the next edge. A same-cycle
//                             push or pop is lost.
//   in_valid/in_ready       : fetch-side handshake. in_ready depends on
//                             state only.
//   in_instr, in_pc, in_pred: fetched entry
//   out_valid/out_ready     : decode-side handshake
//   out_instr, out_pc, out_pred : head entry, or NOP/0/0 when empty
//   opcode..imm_J           : fields of out_instr
//   count                   : occupancy
// Optional build macro IF_ID_QUEUE_STATS_EN adds two outputs:
//   stall_cycles  : saturating count of cycles with out_valid & ~out_ready
//   bubble_cycles : saturating count of cycles with ~out_valid & ~flush
module if_id_queue
   import rv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH+1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [XLEN-1:0]      in_instr,
   input  logic [XLEN-1:0]      in_pc,
   input  logic                 in_pred,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_instr,
   output logic [XLEN-1:0]      out_pc,
   output logic                 out_pred,
   output logic [OPCODE_W-1:0]  opcode,
   output logic [REG_W-1:0]     rd,
   output logic [REG_W-1:0]     rs1,
   output logic [REG_W-1:0]     rs2,
   output logic [FUNCT3_W-1:0]  funct3,
   output logic [FUNCT7_W-1:0]  funct7,
   output logic [IMM12_W-1:0]   imm_I,
   output logic [IMM12_W-1:0]   imm_S,
   output logic [IMM12_W-1:0]   imm_B,
   output logic [IMM20_W-1:0]   imm_U,
   output logic [IMM20_W-1:0]   imm_J,
   output logic [CNT_W-1:0]     count
`ifdef IF_ID_QUEUE_STATS_EN
   ,
   output logic [31:0]          stall_cycles,
   output logic [31:0]          bubble_cycles
`endif
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [XLEN-1:0]  instr_mem [DEPTH];
   logic [XLEN-1:0]  pc_mem    [DEPTH];
   logic [DEPTH-1:0] pred_mem;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;

   assign in_ready  = (count != CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)
            count <= count + CNT_W'(1);
         else if (pop && !push)
            count <= count - CNT_W'(1);
      end
   end

   // Storage is not reset. Entries beyond count are never observed.
   always_ff @(posedge clk) begin
      if (push && !rst && !flush) begin
         instr_mem[wr_ptr] <= in_instr;
         pc_mem[wr_ptr]    <= in_pc;
         pred_mem[wr_ptr]  <= in_pred;
      end
   end

   // An empty queue presents a NOP bubble, so decode needs no special case.
   always_comb begin
      out_instr = NOP_INSTR;
      out_pc    = '0;
      out_pred  = 1'b0;
      if (out_valid) begin
         out_instr = instr_mem[rd_ptr];
         out_pc    = pc_mem[rd_ptr];
         out_pred  = pred_mem[rd_ptr];
      end
   end

   if_id_fields u_fields (
      .instr  (out_instr),
      .opcode (opcode),
      .rd     (rd),
      .rs1    (rs1),
      .rs2    (rs2),
      .funct3 (funct3),
      .funct7 (funct7),
      .imm_I  (imm_I),
      .imm_S  (imm_S),
      .imm_B  (imm_B),
      .imm_U  (imm_U),
      .imm_J  (imm_J)
   );

`ifdef IF_ID_QUEUE_STATS_EN
   // A flush does not clear these counters. The bubble count skips flush
   // cycles, so a redirect's own cycle does not count as a starvation bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles  <= '0;
         bubble_cycles <= '0;
      end else begin
         if (out_valid && !out_ready && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
         if (!out_valid && !flush && bubble_cycles != '1)
            bubble_cycles <= bubble_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- A DEPTH-entry FIFO sits between fetch and decode and holds {instruction, pc, predicted} tuples.
- Valid/ready handshake on both sides. Flush empties the queue in one cycle; a NOP bubble is presented when empty.
- Decode-side instruction fields and raw immediates are extracted from the head entry, so fetch can run ahead of decode stalls.

Parameters:
- XLEN, 32, width of instruction and pc words (instruction field extraction assumes the RV32 encoding; XLEN is 32 only).
- DEPTH, 4, number of queue entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- flush, input, 1, discard all entries (branch mispredict / redirect).
- in_valid, input, 1, fetch presents an entry.
- in_ready, output, 1, queue accepts an entry this cycle.
- in_instr, input, XLEN, fetched instruction.
- in_pc, input, XLEN, pc of the fetched instruction.
- in_pred, input, 1, branch-predicted-taken flag.
- out_valid, output, 1, head entry valid.
- out_ready, input, 1, decode consumes head (low = hazard stall).
- out_instr, output, XLEN, head instruction or NOP.
- out_pc, output, XLEN, head pc or 0.
- out_pred, output, 1, head predicted flag or 0.
- opcode, output, 7, out_instr[6:0].
- rd, output, 5, out_instr[11:7].
- rs1, output, 5, out_instr[19:15].
- rs2, output, 5, out_instr[24:20].
- funct3, output, 3, out_instr[14:12].
- funct7, output, 7, out_instr[31:25].
- imm_I, output, 12, out_instr[31:20].
- imm_S, output, 12, {[31:25],[11:7]}.
- imm_B, output, 12, {[31],[7],[30:25],[11:8]}.
- imm_U, output, 20, [31:12].
- imm_J, output, 20, {[31],[19:12],[20],[30:21]}.
- count, output, CNT_W, current occupancy.

Behaviour:
- Storage: circular buffer with wr_ptr and rd_ptr of $clog2(DEPTH) bits, plus a registered count. Pointers wrap modulo DEPTH naturally.
- Reset (sync, rst high at posedge): wr_ptr=rd_ptr=count=0.
  - Outputs after reset: out_valid=0, out_instr=32'h00000013 (NOP, addi x0,x0,0), out_pc=0, out_pred=0, in_ready=1.
  - Storage contents need not be cleared.
- in_ready = (count != DEPTH). It is a function of state only and must not combinationally depend on out_ready.
- out_valid = (count != 0).
- When out_valid=0, out_instr is forced to NOP and out_pc/out_pred to 0. All field outputs are derived from out_instr, so they decode the NOP.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Latency: an entry pushed at edge N is visible on out_* after edge N (one cycle). There is no same-cycle bypass.
- Simultaneous push and pop are legal whenever both are allowed: both pointers advance and count is unchanged. At count==DEPTH push is blocked even if pop occurs (in_ready low).
- Priority at each edge: rst > flush > push/pop.
  - flush: wr_ptr=rd_ptr=count=0. A same-cycle push is dropped and a same-cycle pop has no effect.
  - in_ready and out_valid are not gated by flush in the same cycle. Fetch must treat the flush cycle's transfer as lost.
- Decode stall: out_ready=0 holds the head and all field outputs stable; fetch continues until full.
- Ordering: strict FIFO. An entry's pc/instr/pred are never separated.
- Reset or flush in the middle of a burst: the next push after deassertion lands at index 0 and appears on out_* one cycle later.

Optional Feature:
- Macro IF_ID_QUEUE_STATS_EN.
- When defined, two extra outputs are added:
  - stall_cycles (32 bits): increments every cycle with out_valid & ~out_ready.
  - bubble_cycles (32 bits): increments every cycle with ~out_valid & ~flush.
  - Both clear on rst, saturate at all-ones, and are not cleared by flush.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package rv_pkg holds:
  - the constant NOP_INSTR = 32'h00000013;
  - field-width constants (OPCODE_W=7, REG_W=5, FUNCT3_W=3, FUNCT7_W=7, IMM12_W=12, IMM20_W=20).
- One sub-module, if_id_fields: purely combinational extraction of opcode/regs/functs/immediates from a 32-bit word. It is shared with any later decode-side stage.

Test Plan:
- Reset then idle → out_valid=0, out_instr=0x00000013, out_pc=0, opcode=0x13, count=0, in_ready=1.
- Push 0x00500093 @pc 0x100, out_ready=1 → next cycle out_valid=1, rd=1, rs1=0, imm_I=0x005, out_pc=0x100; popped the cycle after.
- out_ready=0, push DEPTH=4 entries → count=4, in_ready=0. A fifth in_valid is ignored. Then out_ready=1 → drains in order pc 0x0,0x4,0x8,0xC.
- With count=2, assert push+pop each cycle for 10 cycles → count stays 2, pointers wrap, output order matches input order.
- With count=3 and in_valid=1 and flush=1 in the same cycle → next cycle count=0, out_valid=0, out_instr=NOP. The pushed entry never appears.
- Push instruction 0xFE000EE3 (beq x0,x0,-4), check imm_B=0xFFE and imm_S, imm_J fields. Then assert rst mid-stream → all outputs return to reset values on the next edge.
